// File: rtl/hybrid_switching_controller.sv
`default_nettype none
// ============================================================================
//  Module   : hybrid_switching_controller
//  Purpose  : Closed-loop state-plane switching law for an LLC converter
//             simulator. Produces the signed switch command sigma (+1/0/-1)
//             from the fed-back resonant-capacitor voltage vC and tank current
//             iS. Includes a vC threshold, dead-time insertion, min/max
//             half-period limits and a latched over-current trip.
//  Ports    : CLK          - clock
//             RESET        - asynchronous active-low reset
//             enable       - run request; low forces IDLE and clears fault
//             vc_ref       - signed vC switching threshold (expected > 0)
//             vC, iS       - signed feedback from the converter simulator
//             sigma        - switch command: 01=+1, 00=0, 11=-1
//             state        - FSM state (IDLE=0 POS=1 DT_N=2 NEG=3 DT_P=4 FAULT=5)
//             fault        - latched over-current flag
//             half_period  - length of last completed active half-period
//             switch_pulse - one-cycle strobe when an active half-period ends
//  Revision : 1.0 - initial release
// ============================================================================
module hybrid_switching_controller #(
    parameter int unsigned T_DEAD = 20,
    parameter int unsigned T_MIN  = 100,
    parameter int unsigned T_MAX  = 2000,
    parameter int unsigned I_MAX  = 30000000,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               enable,
    input  logic signed [31:0] vc_ref,
    input  logic signed [31:0] vC,
    input  logic signed [31:0] iS,
    output logic [1:0]         sigma,
    output logic [2:0]         state,
    output logic               fault,
    output logic [CNT_W-1:0]   half_period,
    output logic               switch_pulse
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POS   = 3'd1,
        S_DT_N  = 3'd2,
        S_NEG   = 3'd3,
        S_DT_P  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    // With no dead time the active phases hand over directly to each other.
    localparam state_t c_after_pos = (T_DEAD == 0) ? S_NEG : S_DT_N;
    localparam state_t c_after_neg = (T_DEAD == 0) ? S_POS : S_DT_P;

    // Counter limits compared against counter+1 (one bit wider) so that a
    // zero-valued parameter never needs a negative constant.
    localparam logic [CNT_W:0] c_t_dead = (CNT_W+1)'(T_DEAD);
    localparam logic [CNT_W:0] c_t_min  = (CNT_W+1)'(T_MIN);
    localparam logic [CNT_W:0] c_t_max  = (CNT_W+1)'(T_MAX);
    localparam logic [32:0]    c_i_max  = 33'(I_MAX);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W:0]     w_cnt_p1;
    logic [1:0]         r_sigma;
    logic [1:0]         w_sigma_nxt;
    logic               r_fault;
    logic               w_fault_nxt;
    logic [CNT_W-1:0]   r_half_period;
    logic [CNT_W-1:0]   w_hp_nxt;
    logic               r_pulse;
    logic               w_pulse_nxt;

    logic signed [32:0] w_vc_ext;
    logic signed [32:0] w_ref_ext;
    logic signed [32:0] w_is_ext;
    logic [32:0]        w_is_abs;
    logic               w_oc;
    logic               w_pos_hit;
    logic               w_neg_hit;
    logic               w_min_ok;
    logic               w_timeout;
    logic               w_dead_done;
    logic               w_running;

    // 33-bit sign extension keeps -vc_ref and abs(-2^31) representable.
    assign w_vc_ext  = {vC[31], vC};
    assign w_ref_ext = {vc_ref[31], vc_ref};
    assign w_is_ext  = {iS[31], iS};
    assign w_is_abs  = iS[31] ? $unsigned(-w_is_ext) : $unsigned(w_is_ext);
    assign w_oc      = (w_is_abs > c_i_max);

    assign w_pos_hit = (w_vc_ext >= w_ref_ext);
    assign w_neg_hit = (w_vc_ext <= -w_ref_ext);

    assign w_cnt_p1    = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : w_cnt_p1[CNT_W-1:0];
    assign w_min_ok    = (w_cnt_p1 >= c_t_min);
    assign w_timeout   = (w_cnt_p1 == c_t_max);
    assign w_dead_done = (w_cnt_p1 == c_t_dead);

    assign w_running = (r_state == S_POS) || (r_state == S_NEG) ||
                       (r_state == S_DT_N) || (r_state == S_DT_P);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_inc;
        w_fault_nxt = r_fault;
        w_hp_nxt    = r_half_period;
        w_pulse_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt   = '0;
                w_fault_nxt = 1'b0;
                if (enable) begin
                    w_state_nxt = S_POS;
                end
            end
            S_POS: begin
                // Threshold and timeout in the same cycle are one switch.
                if ((w_pos_hit && w_min_ok) || w_timeout) begin
                    w_state_nxt = c_after_pos;
                    w_cnt_nxt   = '0;
                    w_hp_nxt    = w_cnt_p1[CNT_W-1:0];
                    w_pulse_nxt = 1'b1;
                end
            end
            S_NEG: begin
                if ((w_neg_hit && w_min_ok) || w_timeout) begin
                    w_state_nxt = c_after_neg;
                    w_cnt_nxt   = '0;
                    w_hp_nxt    = w_cnt_p1[CNT_W-1:0];
                    w_pulse_nxt = 1'b1;
                end
            end
            S_DT_N: begin
                if (w_dead_done) begin
                    w_state_nxt = S_NEG;
                    w_cnt_nxt   = '0;
                end
            end
            S_DT_P: begin
                if (w_dead_done) begin
                    w_state_nxt = S_POS;
                    w_cnt_nxt   = '0;
                end
            end
            S_FAULT: begin
                w_cnt_nxt = '0;
                if (!enable) begin
                    w_state_nxt = S_IDLE;
                    w_fault_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // Stop requests override any switching decision: enable=0 first
        // (so a coincident over-current does not latch), then over-current.
        // Neither records a partial half-period.
        if (w_running) begin
            if (!enable) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_hp_nxt    = r_half_period;
                w_pulse_nxt = 1'b0;
            end else if (w_oc) begin
                w_state_nxt = S_FAULT;
                w_cnt_nxt   = '0;
                w_fault_nxt = 1'b1;
                w_hp_nxt    = r_half_period;
                w_pulse_nxt = 1'b0;
            end
        end

        case (w_state_nxt)
            S_POS:   w_sigma_nxt = 2'b01;
            S_NEG:   w_sigma_nxt = 2'b11;
            default: w_sigma_nxt = 2'b00;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_sigma       <= 2'b00;
            r_fault       <= 1'b0;
            r_half_period <= '0;
            r_pulse       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_sigma       <= w_sigma_nxt;
            r_fault       <= w_fault_nxt;
            r_half_period <= w_hp_nxt;
            r_pulse       <= w_pulse_nxt;
        end
    end

    assign sigma        = r_sigma;
    assign state        = r_state;
    assign fault        = r_fault;
    assign half_period  = r_half_period;
    assign switch_pulse = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_hybrid_switching_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hybrid_switching_controller
//  Purpose  : Scoreboard bench for hybrid_switching_controller. Two builds are
//             driven by the same inputs: the default one (dead time 20) and a
//             short one without dead time (T_MIN=5, T_MAX=40).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hybrid_switching_controller;

    localparam int c_i_max = 30000000;

    logic               CLK    = 1'b0;
    logic               RESET  = 1'b1;
    logic               enable = 1'b0;
    logic signed [31:0] vc_ref = 32'sd1000;
    logic signed [31:0] vC     = '0;
    logic signed [31:0] iS     = '0;

    logic [1:0]  sigma0, sigma1;
    logic [2:0]  state0, state1;
    logic        fault0, fault1;
    logic [15:0] hp0, hp1;
    logic        pulse0, pulse1;
    logic [22:0] act0, act1;

    assign act0 = {sigma0, state0, fault0, hp0, pulse0};
    assign act1 = {sigma1, state1, fault1, hp1, pulse1};

    hybrid_switching_controller u_dut (
        .CLK(CLK), .RESET(RESET), .enable(enable), .vc_ref(vc_ref),
        .vC(vC), .iS(iS), .sigma(sigma0), .state(state0), .fault(fault0),
        .half_period(hp0), .switch_pulse(pulse0)
    );

    hybrid_switching_controller #(
        .T_DEAD(0), .T_MIN(5), .T_MAX(40), .I_MAX(30000000), .CNT_W(16)
    ) u_dut_nodt (
        .CLK(CLK), .RESET(RESET), .enable(enable), .vc_ref(vc_ref),
        .vC(vC), .iS(iS), .sigma(sigma1), .state(state1), .fault(fault1),
        .half_period(hp1), .switch_pulse(pulse1)
    );

    always #5 CLK = ~CLK;

    // Reference model: operating mode plus elapsed cycles in the current phase.
    typedef struct packed {
        bit run;    // converter actively switching (incl. dead time)
        bit flt;    // tripped
        bit dead;   // in a zero gap, pol is the polarity that follows
        int pol;    // +1 / -1
        int n;      // cycles already spent in the current phase
        int hp;     // last completed half-period
        bit pulse;
    } mdl_t;

    mdl_t m0, m1;
    logic [22:0] q0[$];
    logic [22:0] q1[$];
    int checks = 0;
    int errors = 0;
    bit release_pending = 1'b0;
    int oc_tab[6];

    function automatic mdl_t step(input mdl_t m, input int tdead, input int tmin,
                                  input int tmax, input bit en, input int vref,
                                  input int vc, input int is);
        mdl_t r;
        longint mag;
        longint len;
        bit crossed;
        r = m;
        r.pulse = 1'b0;
        mag = (is < 0) ? -longint'(is) : longint'(is);
        if (!en) begin
            r.run = 1'b0; r.flt = 1'b0; r.dead = 1'b0; r.n = 0;
        end else if (r.flt) begin
            r.flt = 1'b1;  // latched until enable drops
        end else if (!r.run) begin
            r.run = 1'b1; r.pol = 1; r.dead = 1'b0; r.n = 0;
        end else if (mag > longint'(c_i_max)) begin
            r.run = 1'b0; r.flt = 1'b1; r.dead = 1'b0; r.n = 0;
        end else begin
            len = longint'(r.n) + 1;
            if (r.dead) begin
                if (len == longint'(tdead)) begin
                    r.dead = 1'b0; r.n = 0;
                end else begin
                    r.n = int'(len);
                end
            end else begin
                crossed = (r.pol > 0) ? (longint'(vc) >= longint'(vref))
                                      : (longint'(vc) <= -longint'(vref));
                if (len == longint'(tmax) || (len >= longint'(tmin) && crossed)) begin
                    r.hp = int'(len); r.pulse = 1'b1; r.pol = -r.pol;
                    r.dead = (tdead > 0); r.n = 0;
                end else begin
                    r.n = int'(len);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [22:0] expv(input mdl_t m);
        logic [1:0] sg;
        logic [2:0] st;
        sg = (m.run && !m.dead) ? ((m.pol > 0) ? 2'b01 : 2'b11) : 2'b00;
        if (m.flt)       st = 3'd5;
        else if (!m.run) st = 3'd0;
        else if (m.dead) st = (m.pol < 0) ? 3'd2 : 3'd4;
        else             st = (m.pol > 0) ? 3'd1 : 3'd3;
        return {sg, st, m.flt, m.hp[15:0], m.pulse};
    endfunction

    task automatic cmp(input string nm, input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got sigma=%b state=%0d fault=%b hp=%0d pulse=%b, expected sigma=%b state=%0d fault=%b hp=%0d pulse=%b",
                     nm, $time, act[22:21], act[20:18], act[17], act[16:1], act[0],
                     exp[22:21], exp[20:18], exp[17], exp[16:1], exp[0]);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, queue expectation.
    task automatic tick(input bit en, input int vref, input int vc, input int is);
        @(negedge CLK);
        enable = en; vc_ref = vref; vC = vc; iS = is;
        if (release_pending) begin
            RESET = 1'b1;
            release_pending = 1'b0;
        end
        if (RESET) begin
            m0 = step(m0, 20, 100, 2000, en, vref, vc, is);
            m1 = step(m1, 0, 5, 40, en, vref, vc, is);
        end
        q0.push_back(expv(m0));
        q1.push_back(expv(m1));
    endtask

    task automatic do_reset(input int hold);
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        cmp("async_reset_dt", act0, 23'd0);
        cmp("async_reset_nodt", act1, 23'd0);
        m0 = '0;
        m1 = '0;
        for (int h = 0; h < hold; h++) tick(1'b1, 1000, 0, 0);
        release_pending = 1'b1;
    endtask

    function automatic int pick_vc(input int vref);
        case ($urandom_range(0, 7))
            0:       return vref;
            1:       return vref - 1;
            2:       return -vref;
            3:       return -vref + 1;
            4, 5:    return 0;
            default: return int'($urandom_range(0, 4 * vref)) - 2 * vref;
        endcase
    endfunction

    function automatic int pick_is();
        return int'($urandom_range(0, 2000000)) - 1000000;
    endfunction

    // Monitor: every sampled clock compares DUT outputs with queued expectations.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (q0.size() > 0) cmp("dut_dt", act0, q0.pop_front());
            if (q1.size() > 0) cmp("dut_nodt", act1, q1.pop_front());
        end
    end

    initial begin
        int vref;
        int len;
        int mode;
        int n;
        bit en;
        int is;

        oc_tab[0] = 30000001;
        oc_tab[1] = -30000001;
        oc_tab[2] = int'(32'h8000_0000);
        oc_tab[3] = 30000000;
        oc_tab[4] = -30000000;
        oc_tab[5] = 2147483647;

        #2 RESET = 1'b0;
        #1;
        cmp("reset_dt", act0, 23'd0);
        cmp("reset_nodt", act1, 23'd0);
        m0 = '0;
        m1 = '0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1000, 0, 0);
        release_pending = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1000, 0, 0);

        // Directed opening: trips at the iS boundaries and enable dominance.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 30; i++) tick(1'b1, 1000, 0, 0);
            tick(1'b1, 1000, 0, oc_tab[k]);
            for (int i = 0; i < 4; i++) tick(1'b1, 1000, 0, 0);
            tick(1'b0, 1000, 0, 0);
        end
        for (int i = 0; i < 10; i++) tick(1'b1, 1000, 0, 30000000);
        tick(1'b0, 1000, 0, 30000001);
        tick(1'b0, 1000, 0, 0);

        // Randomised segments.
        for (int s = 0; s < 24; s++) begin
            mode = int'($urandom_range(0, 3));
            vref = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3000)) : 1000;
            len  = (mode == 0) ? int'($urandom_range(2100, 4300)) : int'($urandom_range(300, 1500));
            for (int c = 0; c < len; c++) begin
                en = ($urandom_range(0, 799) != 0);
                is = pick_is();
                if (mode == 3 && $urandom_range(0, 99) == 0) is = oc_tab[$urandom_range(0, 5)];
                tick(en, vref, (mode == 0) ? 0 : pick_vc(vref), is);
            end
            if (mode == 3 || $urandom_range(0, 1) == 0) begin
                n = int'($urandom_range(1, 3));
                for (int c = 0; c < n; c++) tick(1'b0, vref, 0, 0);
            end
        end

        // Async reset while the default build sits in dead time.
        tick(1'b0, 1000, 0, 0);
        tick(1'b0, 1000, 0, 0);
        n = 0;
        while (!m0.dead && n < 5000) begin
            tick(1'b1, 1000, 2000, 0);
            n++;
        end
        checks++;
        if (!m0.dead) begin
            errors++;
            $display("FAIL dt_wait: dead time not reached after %0d cycles, required within 5000", n);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1000, 2000, 0);
        do_reset(2);
        for (int i = 0; i < 600; i++) tick(1'b1, 1000, pick_vc(1000), pick_is());

        repeat (3) @(posedge CLK);
        #2;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0/0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
